// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Local data RAM that answers pipeline data-memory requests after a fixed
//   latency. Each accepted request performs exactly one word read or one
//   byte-masked write. The access happens on the clock edge that enters RESP.
//   Out-of-range, misaligned and instruction-fetch stores are flagged
//   with mem_error and leave the RAM untouched.
//
// Parameters
//   DEPTH_LOG2  log2 of the number of 32-bit RAM words (4..16)
//   LATENCY     cycles from request acceptance to mem_ready (1..15)
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   mem_valid  single-cycle request strobe
//   mem_instr  request is an instruction fetch
//   mem_addr   byte address
//   mem_wdata  store data, lane-replicated by the initiator
//   mem_wstrb  byte write enables, 0 = read
//   mem_ready  one-cycle completion pulse (registered)
//   mem_rdata  read data, nonzero only with mem_ready (registered)
//   mem_error  error flag, coincident with mem_ready (registered)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // The WAIT phase covers LATENCY-1 cycles, so the counter starts at LATENCY-2.
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;

  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] ram [2**DEPTH_LOG2];

  logic        accept;
  logic        enter_resp;

  // Request as seen at the edge entering RESP. With LATENCY=1 that edge is
  // the acceptance edge itself, so the holding registers are not loaded yet
  // and the live inputs are used instead.
  logic [31:0]           req_addr, req_wdata;
  logic [3:0]            req_wstrb;
  logic                  req_instr;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_oor, req_misal, req_fstore, req_err;
  logic                  ram_we;

  assign accept     = mem_valid && ((state_q == S_IDLE) || (state_q == S_RESP));
  assign enter_resp = (state_d == S_RESP);

  always_comb begin
    if (state_q == S_WAIT) begin
      req_addr  = addr_q;
      req_wdata = wdata_q;
      req_wstrb = wstrb_q;
      req_instr = instr_q;
    end else begin
      req_addr  = mem_addr;
      req_wdata = mem_wdata;
      req_wstrb = mem_wstrb;
      req_instr = mem_instr;
    end
  end

  assign req_idx     = req_addr[DEPTH_LOG2+1:2];
  assign req_oor     = (req_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
  assign req_misal   = ((req_wstrb == 4'b1111) && (req_addr[1:0] != 2'b00)) ||
                       (((req_wstrb == 4'b0011) || (req_wstrb == 4'b1100)) && req_addr[0]);
  assign req_fstore  = req_instr && (req_wstrb != 4'b0000);
  assign req_err     = req_oor || req_misal || req_fstore;
  // Reset gating: a request racing an asserted reset must never write.
  assign ram_we      = enter_resp && !rst && !req_err && (req_wstrb != 4'b0000);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // New strobes are dropped here, not queued.
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: computed for the edge entering RESP, then registered.
  always_comb begin
    ready_d = enter_resp;
    error_d = enter_resp && req_err;
    rdata_d = 32'd0;
    if (enter_resp && !req_err && (req_wstrb == 4'b0000)) begin
      rdata_d = ram[req_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ready_q <= ready_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
    end
  end

  // Holding registers carry data only, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
      instr_q <= mem_instr;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb[i]) begin
          ram[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_error = error_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        v1, v4, v3;
  logic        instr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;

  logic        r1, e1, r4, e4, r3, e3;
  logic [31:0] d1, d4, d3;

  int tests;
  int fails;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .mem_valid(v1), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(r1), .mem_rdata(d1), .mem_error(e1));

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .mem_valid(v4), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(r4), .mem_rdata(d4), .mem_error(e4));

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .mem_valid(v3), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(r3), .mem_rdata(d3), .mem_error(e3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic i, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    instr = i;
    addr  = a;
    wdata = d;
    wstrb = s;
  endtask

  // One LATENCY=1 request: strobe for one cycle, leave the bench in the
  // response cycle.
  task automatic l1_op(input logic i, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    set_req(i, a, d, s);
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    v1 = 1'b0; v4 = 1'b0; v3 = 1'b0;
    set_req(1'b0, 32'd0, 32'd0, 4'd0);

    // Reset state
    repeat (2) tick();
    chk("rst_ready_l1", {31'd0, r1}, 32'd0);
    chk("rst_error_l1", {31'd0, e1}, 32'd0);
    chk("rst_rdata_l1", d1, 32'd0);
    chk("rst_ready_l4", {31'd0, r4}, 32'd0);
    chk("rst_ready_l3", {31'd0, r3}, 32'd0);
    rst = 1'b0;

    // Word write then read, first request right after reset release
    l1_op(1'b0, 32'h40, 32'hDEADBEEF, 4'b1111);
    chk("wr40_ready", {31'd0, r1}, 32'd1);
    chk("wr40_error", {31'd0, e1}, 32'd0);
    chk("wr40_rdata", d1, 32'd0);
    tick();
    chk("idle_ready", {31'd0, r1}, 32'd0);
    l1_op(1'b0, 32'h40, 32'h0, 4'b0000);
    chk("rd40_ready", {31'd0, r1}, 32'd1);
    chk("rd40_rdata", d1, 32'hDEADBEEF);
    chk("rd40_error", {31'd0, e1}, 32'd0);
    // Asynchronous reset clears outputs without a clock edge
    rst = 1'b1;
    #1;
    chk("async_rst_ready", {31'd0, r1}, 32'd0);
    chk("async_rst_rdata", d1, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Byte lane write
    l1_op(1'b0, 32'h80, 32'h0, 4'b1111);
    tick();
    l1_op(1'b0, 32'h80, 32'hAAAAAAAA, 4'b0100);
    tick();
    l1_op(1'b0, 32'h80, 32'h0, 4'b0000);
    chk("lane_rdata", d1, 32'h00AA0000);
    tick();

    // Error cases
    l1_op(1'b0, 32'h42, 32'h12345678, 4'b1111);
    chk("misal_word_ready", {31'd0, r1}, 32'd1);
    chk("misal_word_error", {31'd0, e1}, 32'd1);
    chk("misal_word_rdata", d1, 32'd0);
    tick();
    l1_op(1'b0, 32'h41, 32'h55555555, 4'b0011);
    chk("misal_half_error", {31'd0, e1}, 32'd1);
    tick();
    l1_op(1'b0, 32'h0010_0000, 32'h0, 4'b0000);
    chk("oor_error", {31'd0, e1}, 32'd1);
    chk("oor_rdata", d1, 32'd0);
    tick();
    l1_op(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0001);
    chk("fstore_error", {31'd0, e1}, 32'd1);
    tick();
    l1_op(1'b0, 32'h40, 32'h0, 4'b0000);
    chk("after_err_rdata", d1, 32'hDEADBEEF);
    chk("after_err_error", {31'd0, e1}, 32'd0);
    tick();

    // Back-to-back at LATENCY=1
    l1_op(1'b0, 32'h4, 32'h22, 4'b1111);
    tick();
    set_req(1'b0, 32'h0, 32'h11, 4'b1111);
    v1 = 1'b1;
    tick();
    chk("b2b_c1_ready", {31'd0, r1}, 32'd1);
    chk("b2b_c1_rdata", d1, 32'd0);
    set_req(1'b0, 32'h0, 32'h0, 4'b0000);
    tick();
    chk("b2b_c2_ready", {31'd0, r1}, 32'd1);
    chk("b2b_c2_rdata", d1, 32'h00000011);
    set_req(1'b0, 32'h4, 32'h0, 4'b0000);
    tick();
    v1 = 1'b0;
    chk("b2b_c3_ready", {31'd0, r1}, 32'd1);
    chk("b2b_c3_rdata", d1, 32'h00000022);
    tick();
    chk("b2b_c4_ready", {31'd0, r1}, 32'd0);

    // LATENCY=4: preload, then read with extra strobes in WAIT
    set_req(1'b0, 32'h40, 32'h0BADF00D, 4'b1111);
    v4 = 1'b1;
    tick();
    v4 = 1'b0;
    repeat (5) tick();
    set_req(1'b0, 32'h40, 32'h0, 4'b0000);
    v4 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) begin
        chk($sformatf("l4_wait_c%0d_ready", k), {31'd0, r4}, 32'd0);
      end else begin
        v4 = 1'b0;
        chk("l4_c4_ready", {31'd0, r4}, 32'd1);
        chk("l4_c4_rdata", d4, 32'h0BADF00D);
        chk("l4_c4_error", {31'd0, e4}, 32'd0);
      end
    end
    for (int k = 5; k <= 9; k++) begin
      tick();
      chk($sformatf("l4_extra_c%0d_ready", k), {31'd0, r4}, 32'd0);
    end

    // LATENCY=3: reset one cycle after a write is accepted
    set_req(1'b0, 32'h100, 32'h55555555, 4'b1111);
    v3 = 1'b1;
    tick();
    v3 = 1'b0;
    repeat (4) tick();
    set_req(1'b0, 32'h100, 32'h99999999, 4'b1111);
    v3 = 1'b1;
    tick();
    v3 = 1'b0;
    rst = 1'b1;
    #1;
    chk("l3_rst_ready", {31'd0, r3}, 32'd0);
    chk("l3_rst_rdata", d3, 32'd0);
    chk("l3_rst_error", {31'd0, e3}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("l3_in_rst_%0d_ready", k), {31'd0, r3}, 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("l3_after_rst_%0d_ready", k), {31'd0, r3}, 32'd0);
    end
    set_req(1'b0, 32'h100, 32'h0, 4'b0000);
    v3 = 1'b1;
    tick();
    v3 = 1'b0;
    tick();
    chk("l3_rd_c2_ready", {31'd0, r3}, 32'd0);
    tick();
    chk("l3_rd_c3_ready", {31'd0, r3}, 32'd1);
    chk("l3_rd_c3_rdata", d3, 32'h55555555);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
